// File: rtl/lfsr_bist_ctrl_if.sv
// Memory port bundle between the BIST sequencer and the memory port mux.
// The controller drives the master side; the mux (or its model) drives mem_rdata.
interface lfsr_bist_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              mem_cs;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata;

    modport master (
        output mem_cs, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_cs, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/lfsr_bist_ctrl.sv
// Memory BIST sequencer: writes an LFSR pattern, restarts the LFSR, replays it
// against the read-back data and reports pass, mismatch count and first bad address.
module lfsr_bist_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic [ADDR_W-1:0] fail_addr,
    output logic              lfsr_en,
    input  logic [15:0]       lfsr_q,
    lfsr_bist_ctrl_if.master  mem
);
    typedef enum logic [2:0] {IDLE, WRITE, GAP, READ, FLUSH, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] cmp_addr;
    logic [15:0]       exp_q;
    logic              cmp_vld;
    logic              cs, we;
    logic              last;
    logic              mismatch;
    logic              accept;

    assign last     = (addr == LAST);
    assign accept   = (state == IDLE) && start;
    assign mismatch = cmp_vld && (mem.mem_rdata != exp_q);

    assign mem.mem_cs    = cs;
    assign mem.mem_we    = we;
    assign mem.mem_addr  = addr;
    assign mem.mem_wdata = lfsr_q;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        lfsr_en   = 1'b0;
        cs        = 1'b0;
        we        = 1'b0;
        unique case (state)
            IDLE:  if (start) state_nxt = WRITE;
            WRITE: begin
                busy    = 1'b1;
                cs      = 1'b1;
                we      = 1'b1;
                lfsr_en = 1'b1;
                if (last) state_nxt = GAP;
            end
            // LFSR disabled for one cycle so it reloads its seed before replay
            GAP: begin
                busy      = 1'b1;
                state_nxt = READ;
            end
            READ: begin
                busy    = 1'b1;
                cs      = 1'b1;
                lfsr_en = 1'b1;
                if (last) state_nxt = FLUSH;
            end
            FLUSH: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr      <= '0;
            cmp_addr  <= '0;
            exp_q     <= '0;
            cmp_vld   <= 1'b0;
            fail_cnt  <= '0;
            fail_addr <= '0;
            pass      <= 1'b0;
        end else begin
            // Expected word and its address travel alongside the 1-cycle read latency
            cmp_vld <= (state == READ);
            if (state == READ) begin
                exp_q    <= lfsr_q;
                cmp_addr <= addr;
            end

            if (accept)
                addr <= '0;
            else if (state == WRITE || state == READ)
                addr <= last ? '0 : addr + ADDR_W'(1);

            if (accept) begin
                fail_cnt  <= '0;
                fail_addr <= '0;
                pass      <= 1'b0;
            end else if (mismatch) begin
                if (fail_cnt != {CNT_W{1'b1}}) fail_cnt <= fail_cnt + CNT_W'(1);
                if (fail_cnt == '0)            fail_addr <= cmp_addr;
            end

            // Final compare lands on the same edge, so fold it into the verdict
            if (state == FLUSH)
                pass <= (fail_cnt == '0) && !mismatch;
        end
    end
endmodule

// File: tb/tb_lfsr_bist_ctrl.sv
// Bench for lfsr_bist_ctrl: two instances (DEPTH 4 and 256) with LFSR and memory
// models, a per-cycle reference model per instance and directed scenarios.
module tb_lfsr_bist_ctrl;
    localparam int ADDR_W = 8;
    localparam int CNT_W  = 8;
    localparam int MAXC   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    logic [15:0]       pat   [256];
    logic              start [2];
    int                mode  [2];
    logic              busy_w [2];
    logic              done_w [2];
    logic              pass_w [2];
    logic              en_w   [2];
    logic              cs_w   [2];
    logic [CNT_W-1:0]  cnt_w  [2];
    logic [ADDR_W-1:0] fad_w  [2];

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    endfunction

    // mode 0: clean, 1: addr 2 reads 0000, 2: every read returns FFFF
    function automatic logic [15:0] corrupt(input logic [15:0] v, input int a, input int m);
        case (m)
            1:       return (a == 2) ? 16'h0000 : v;
            2:       return 16'hFFFF;
            default: return v;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int D = (g == 0) ? 4 : 256;

        lfsr_bist_ctrl_if #(.ADDR_W(ADDR_W)) mem_bus ();
        logic [15:0] lq = 16'h0001;
        logic [15:0] ram [256];

        lfsr_bist_ctrl #(.ADDR_W(ADDR_W), .DEPTH(D), .CNT_W(CNT_W)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start[g]),
            .busy      (busy_w[g]),
            .done      (done_w[g]),
            .pass      (pass_w[g]),
            .fail_cnt  (cnt_w[g]),
            .fail_addr (fad_w[g]),
            .lfsr_en   (en_w[g]),
            .lfsr_q    (lq),
            .mem       (mem_bus.master)
        );

        assign cs_w[g] = mem_bus.mem_cs;

        always @(posedge clk) lq <= en_w[g] ? lfsr_next(lq) : 16'h0001;

        always @(posedge clk) begin
            if (mem_bus.mem_cs) begin
                if (mem_bus.mem_we) ram[mem_bus.mem_addr] <= mem_bus.mem_wdata;
                else mem_bus.mem_rdata <= corrupt(ram[mem_bus.mem_addr], int'(mem_bus.mem_addr), mode[g]);
            end
        end

        // Reference model: k = cycles since the accepted start (0 = idle).
        initial begin : model
            int  k, n, raw, ecnt, eadr, hcnt, hadr;
            bit  hpass, epass, ewe, ecs, ebusy;
            bit  bad [256];
            k = 0; hcnt = 0; hadr = 0; hpass = 0;
            forever begin
                @(negedge clk);
                if (!rst) begin
                    ewe   = (k >= 1 && k <= D);
                    ecs   = ewe || (k >= D + 2 && k <= 2 * D + 1);
                    ebusy = (k >= 1 && k <= 2 * D + 2);
                    if (k == 0) begin
                        ecnt = hcnt; eadr = hadr; epass = hpass;
                    end else begin
                        n = k - D - 3;
                        if (n < 0) n = 0;
                        if (n > D) n = D;
                        raw = 0; eadr = 0;
                        for (int a = 0; a < n; a++)
                            if (bad[a]) begin
                                if (raw == 0) eadr = a;
                                raw++;
                            end
                        ecnt  = (raw > MAXC) ? MAXC : raw;
                        epass = (k == 2 * D + 3) && (raw == 0);
                    end
                    chk($sformatf("i%0d_busy", g),      int'(busy_w[g]), int'(ebusy));
                    chk($sformatf("i%0d_done", g),      int'(done_w[g]), int'(k == 2 * D + 3));
                    chk($sformatf("i%0d_pass", g),      int'(pass_w[g]), int'(epass));
                    chk($sformatf("i%0d_fail_cnt", g),  int'(cnt_w[g]),  ecnt);
                    chk($sformatf("i%0d_fail_addr", g), int'(fad_w[g]),  eadr);
                    chk($sformatf("i%0d_lfsr_en", g),   int'(en_w[g]),   int'(ecs));
                    chk($sformatf("i%0d_mem_cs", g),    int'(mem_bus.mem_cs), int'(ecs));
                    if (ecs) begin
                        chk($sformatf("i%0d_mem_we", g),   int'(mem_bus.mem_we), int'(ewe));
                        chk($sformatf("i%0d_mem_addr", g), int'(mem_bus.mem_addr), ewe ? k - 1 : k - D - 2);
                    end
                    if (ewe)
                        chk($sformatf("i%0d_mem_wdata", g), int'(mem_bus.mem_wdata), int'(pat[k - 1]));
                end
                if (rst) begin
                    k = 0; hcnt = 0; hadr = 0; hpass = 0;
                end else if (k == 0) begin
                    if (start[g]) begin
                        k = 1; hcnt = 0; hadr = 0; hpass = 0;
                        for (int a = 0; a < D; a++)
                            bad[a] = (corrupt(pat[a], a, mode[g]) != pat[a]);
                    end
                end else if (k == 2 * D + 3) begin
                    k = 0; hcnt = ecnt; hadr = eadr; hpass = epass;
                end else begin
                    k++;
                end
            end
        end
    end

    task automatic do_start(input int g);
        @(posedge clk); #1 start[g] = 1'b1;
        @(posedge clk); #1 start[g] = 1'b0;
    endtask

    // Counts cycles after the start edge; first_n is the cycle index of the first negedge seen.
    task automatic wait_done(input int g, input int first_n, input int maxc, output int lat);
        lat = -1;
        for (int n = first_n; n <= maxc; n++) begin
            @(negedge clk);
            if (done_w[g]) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin : main
        int lat;
        pat[0] = 16'h0001;
        for (int i = 1; i < 256; i++) pat[i] = lfsr_next(pat[i - 1]);
        start[0] = 1'b0; start[1] = 1'b0;
        mode[0]  = 0;    mode[1]  = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_busy",      int'(busy_w[0]), 0);
        chk("rst_done",      int'(done_w[0]), 0);
        chk("rst_pass",      int'(pass_w[0]), 0);
        chk("rst_fail_cnt",  int'(cnt_w[0]),  0);
        chk("rst_fail_addr", int'(fad_w[0]),  0);
        chk("rst_lfsr_en",   int'(en_w[0]),   0);
        chk("rst_mem_cs",    int'(cs_w[1]),   0);
        chk("rst_mem_addr",  int'(g_inst[0].mem_bus.mem_addr), 0);
        chk("pat0", int'(pat[0]), 16'h0001);
        chk("pat1", int'(pat[1]), 16'h0002);
        chk("pat2", int'(pat[2]), 16'h0004);
        chk("pat3", int'(pat[3]), 16'h0008);

        // Clean DEPTH=4 run
        do_start(0);
        wait_done(0, 1, 50, lat);
        chk("clean_latency",   lat, 11);
        chk("clean_pass",      int'(pass_w[0]), 1);
        chk("clean_fail_cnt",  int'(cnt_w[0]),  0);
        chk("clean_fail_addr", int'(fad_w[0]),  0);

        // Back-to-back: stuck-at on addr 2
        mode[0] = 1;
        do_start(0);
        wait_done(0, 1, 50, lat);
        chk("stuck_latency",   lat, 11);
        chk("stuck_pass",      int'(pass_w[0]), 0);
        chk("stuck_fail_cnt",  int'(cnt_w[0]),  1);
        chk("stuck_fail_addr", int'(fad_w[0]),  2);

        // Back-to-back again: results cleared, plus a stray start during WRITE
        mode[0] = 0;
        do_start(0);
        @(negedge clk);
        chk("b2b_cleared_cnt",  int'(cnt_w[0]), 0);
        chk("b2b_cleared_addr", int'(fad_w[0]), 0);
        @(posedge clk); #1 start[0] = 1'b1;
        @(posedge clk); #1 start[0] = 1'b0;
        wait_done(0, 3, 50, lat);
        chk("stray_start_latency", lat, 11);
        chk("b2b_pass",            int'(pass_w[0]), 1);

        // All reads FFFF at DEPTH=256: counter saturates
        mode[1] = 2;
        do_start(1);
        wait_done(1, 1, 600, lat);
        chk("sat_latency",   lat, 515);
        chk("sat_fail_cnt",  int'(cnt_w[1]), 255);
        chk("sat_fail_addr", int'(fad_w[1]), 0);
        chk("sat_pass",      int'(pass_w[1]), 0);

        // Reset during READ of addr 5 (cycle 256+2+5)
        mode[1] = 0;
        do_start(1);
        repeat (262) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy",     int'(busy_w[1]), 0);
        chk("midrst_mem_cs",   int'(cs_w[1]),   0);
        chk("midrst_fail_cnt", int'(cnt_w[1]),  0);

        do_start(1);
        wait_done(1, 1, 600, lat);
        chk("rerun_latency",  lat, 515);
        chk("rerun_pass",     int'(pass_w[1]), 1);
        chk("rerun_fail_cnt", int'(cnt_w[1]),  0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
